muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the MIPS execute stage's iterative multiply/divide unit, producing HI/LO for MULT, MULTU, DIV and DIVU.
- Accepts an operation from EX, runs a WIDTH-cycle shift-add multiply or restoring divide, and holds the pipeline via `stall` until HI/LO are valid.
- Also stalls MFHI/MFLO reads and MTHI/MTLO writes that would collide with a running operation.

## Interface
- `WIDTH`, default 32: operand width; HI/LO are WIDTH bits each.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: a mult/div instruction is in EX; sampled only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val` in WIDTH: multiplicand/dividend; also MTHI/MTLO data.
- `rt_val` in WIDTH: multiplier/divisor.
- `flush` in 1: abort the operation in flight.
- `mf_req` in 1: MFHI/MFLO in EX.
- `mt_hi`, `mt_lo` in 1 each: MTHI/MTLO in EX.
- `hi`, `lo` out WIDTH: architectural HI/LO registers.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE (one-cycle pulse).
- `stall` out 1: hold IF/ID/EX this cycle.

## Operation
- States:
  - IDLE → RUN on `start` (not flushed, divisor nonzero or multiply).
  - IDLE → DONE on `start` with DIV/DIVU and `rt_val`==0.
  - RUN → DONE when `count` reaches 0.
  - DONE → IDLE unconditionally.
- `flush`: forces IDLE at the next edge from any state and has priority over `start`. HI/LO are unchanged and partial results are discarded.
- On accept, latch the operand magnitudes (absolute value for signed ops), the sign flags and `op`; load `count` with WIDTH-1.
- MULT/MULTU: 2·WIDTH-bit accumulator with one add-shift per RUN cycle. Signed: negate the 2·WIDTH-bit product when the operand signs differ. HI = upper half, LO = lower half.
- DIV/DIVU: restoring division with one quotient bit per RUN cycle. Signed: negate the quotient if the signs differ; the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- -2^(WIDTH-1) / -1 gives LO = 0x80000000 and HI = 0 (natural wrap).
- Divide by zero: no RUN phase. HI ← `rs_val`, LO ← all ones, written on the IDLE→DONE edge.
- HI/LO are written only on the RUN→DONE edge (or the div-zero IDLE→DONE edge), or by MTHI/MTLO.
- MTHI/MTLO write `rs_val` at the edge when the state is IDLE or DONE. In RUN the write is held off by `stall`. If MTHI/MTLO and a result write coincide in DONE, the result write (previous edge) already landed, so the MT write wins.
- `stall` = (IDLE & `start` & ~`flush`) | (RUN & ~`flush`) | (RUN & (`mf_req` | `mt_hi` | `mt_lo`)).
- `stall` is low in DONE: the issuing instruction advances, and its still-high `start` is ignored because it is not sampled in DONE.
- Reset (async, at any time including mid-RUN): state IDLE, `count`=0, `hi`=`lo`=0, accumulators 0, `busy`=`done`=0. `stall` is then 0 unless `start` is high.

## Timing
- Cycle 0: `start` high in IDLE, `stall`=1.
- Cycles 1..WIDTH: RUN, `busy`=1, `stall`=1.
- Cycle WIDTH+1: DONE, `done`=1, `stall`=0, new HI/LO visible.
- Total: the pipeline is held WIDTH+1 cycles (33 for WIDTH=32).
- Div-by-zero: stall only in cycle 0; DONE in cycle 1 with the result visible.
- `hi`, `lo`, `busy` and `done` are registered. `stall` is combinational from state and inputs.
- Back-to-back ops: the next `start` can be accepted in the IDLE cycle following DONE, so there is a minimum of one non-stall cycle between ops.

## Structure
- Shared `mips_pkg`:
  - op encodings `MD_MULT`/`MD_MULTU`/`MD_DIV`/`MD_DIVU`;
  - the state enum `MD_IDLE`/`MD_RUN`/`MD_DONE`;
  - `WIDTH` default constant.
- Single module; no sub-module. The add-shift and subtract-restore datapaths share one WIDTH+1-bit adder selected by `op`.

## Test plan
- MULT `rs_val`=7, `rt_val`=0xFFFFFFFD → `stall` high 33 cycles, then `done`; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 → `lo`=14, `hi`=2.
- DIVU 100/0 → `stall` 1 cycle, DONE next cycle; `hi`=0x64, `lo`=0xFFFFFFFF.
- MULT running: `mf_req` at RUN cycle 5 → `stall` stays 1. Then assert `flush` at RUN cycle 10 → IDLE next edge; `hi`/`lo` keep prior values; `stall`=0.
- `rst_n` low at RUN cycle 20 → `hi`=`lo`=0, `busy`=0 immediately. MTHI 0x1234 in IDLE → `hi`=0x1234 next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op encodings, sequencer states and default width.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // Divide ops are the upper half of the encoding space.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer for the EX stage. Runs one shift-add (multiply) or
// restoring-subtract (divide) step per cycle on magnitudes, fixes signs on the last step and
// writes HI/LO; holds the pipeline with a combinational stall while the unit is busy.
module muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             mf_req,
  input  logic             mt_hi,
  input  logic             mt_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CntW-1:0]    count_q, count_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               run_div;
  logic [WIDTH:0]     add_a, add_b;
  logic [WIDTH+1:0]   add_res;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  logic               sgn_rs, sgn_rt;
  logic [WIDTH-1:0]   mag_rs, mag_rt;

  // Operand signs and magnitudes at accept; unsigned ops never negate.
  always_comb begin
    sgn_rs = ~op[0] & rs_val[WIDTH-1];
    sgn_rt = ~op[0] & rt_val[WIDTH-1];
    mag_rs = sgn_rs ? -rs_val : rs_val;
    mag_rt = sgn_rt ? -rt_val : rt_val;
  end

  // Shared WIDTH+1-bit adder: adds the multiplicand, or subtracts the divisor (carry-out = fits).
  always_comb begin
    run_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
    if (run_div) begin
      add_a = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_b = ~{1'b0, opnd_q};
    end else begin
      add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b = {1'b0, opnd_q};
    end
    add_res = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, run_div};
  end

  // One iteration step plus the sign-corrected result used on the final step.
  always_comb begin
    if (run_div) begin
      if (add_res[WIDTH+1]) begin
        acc_step = {add_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_step = {add_res[WIDTH:0], acc_q[WIDTH-1:1]};
      end else begin
        acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
    prod = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
    quo  = (neg_a_q ^ neg_b_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    // Remainder follows the dividend's sign.
    rem  = neg_a_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    res_hi = run_div ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = run_div ? quo : prod[WIDTH-1:0];
  end

  // Sequencer next state, operand capture and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          if (md_is_div(op) && (rt_val == '0)) begin
            state_d = MD_DONE;
            hi_d    = rs_val;
            lo_d    = '1;
          end else begin
            state_d = MD_RUN;
            op_d    = md_op_e'(op);
            count_d = CntW'(WIDTH - 1);
            neg_a_d = sgn_rs;
            neg_b_d = sgn_rt;
            if (md_is_div(op)) begin
              acc_d  = {{WIDTH{1'b0}}, mag_rs};
              opnd_d = mag_rt;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, mag_rt};
              opnd_d = mag_rs;
            end
          end
        end
      end
      MD_RUN: begin
        if (!flush) begin
          acc_d = acc_step;
          if (count_q == '0) begin
            state_d = MD_DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end else begin
            count_d = count_q - CntW'(1);
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase

    if (flush) begin
      state_d = MD_IDLE;
    end

    // MTHI/MTLO land when not running; in DONE they overwrite the result written last edge.
    if ((state_q == MD_IDLE) || (state_q == MD_DONE)) begin
      if (mt_hi) hi_d = rs_val;
      if (mt_lo) lo_d = rs_val;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MULT;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs: HI/LO and status straight from registers, stall from state and EX inputs.
  always_comb begin
    hi    = hi_q;
    lo    = lo_q;
    busy  = (state_q == MD_RUN);
    done  = (state_q == MD_DONE);
    stall = ((state_q == MD_IDLE) && start && !flush) ||
            ((state_q == MD_RUN) && !flush) ||
            ((state_q == MD_RUN) && (mf_req || mt_hi || mt_lo));
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver issues ops and queues model results, a monitor
// pops and compares whenever done is presented.
module tb_muldiv_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         flush = 1'b0;
  logic         mf_req = 1'b0;
  logic         mt_hi = 1'b0;
  logic         mt_lo = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;
  logic [63:0] mon_exp;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .mf_req(mf_req), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = ua * ub; return p; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: hi=%h lo=%h with no result pending", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result_hilo", {hi, lo}, mon_exp);
      end
    end
  end

  // Issue one op, hold start while stalled, check the stall length and done pulse.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit dz;
    dz = o[1] && (b == 0);
    last_res = model(o, a, b);
    exp_q.push_back(last_res);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) n++;
      else break;
    end
    chk("stall_cycles", 64'(n), dz ? 64'd1 : 64'(W + 1));
    chk("done_after_stall", {63'b0, done}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;

    // Reset state.
    #12;
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy_done_stall", {61'b0, busy, done, stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed ops.
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD);
    chk("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'b0, lo}, 64'hFFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b11, 32'd100, 32'd0);
    chk("divzero_hi", {32'b0, hi}, 64'h64);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd17, 32'hFFFF_FFFB);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(o, a, b);
    end

    // Known nonzero HI/LO before the abort and reset scenarios.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // MFHI during RUN stalls; flush aborts without touching HI/LO.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd5;
    repeat (5) @(posedge clk);
    #1 mf_req = 1'b1;
    @(negedge clk);
    chk("mf_stall_in_run", {62'b0, busy, stall}, 64'd3);
    @(posedge clk); #1;
    mf_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("flush_cycle_stall", {62'b0, busy, stall}, 64'd2);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("after_flush_status", {61'b0, busy, done, stall}, 64'd0);
    chk("after_flush_hilo", {hi, lo}, last_res);
    repeat (40) @(posedge clk);
    chk("flush_no_result", {32'b0, hi}, {32'b0, last_res[63:32]});

    // Asynchronous reset in RUN.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0; start = 1'b0;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    chk("async_reset_status", {61'b0, busy, done, stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // MTHI / MTLO in IDLE.
    @(posedge clk); #1;
    mt_hi = 1'b1; rs_val = 32'h1234;
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b1; rs_val = 32'hABCD;
    @(negedge clk);
    chk("mthi", {32'b0, hi}, 64'h1234);
    @(posedge clk); #1;
    mt_lo = 1'b0;
    @(negedge clk);
    chk("mtlo", {hi, lo}, {32'h1234, 32'hABCD});

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
